// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button front end.
//  - Default configuration for the conditioner (channel count, debounce
//    length, auto-repeat timing and per-channel repeat enables).
//  - Channel FSM state encodings (3 bits).
//  - Channel indices matching the board pushbutton order.
package button_conditioner_pkg;

  localparam int BTN_N                 = 6;
  localparam int DEF_DEBOUNCE_CYCLES   = 4;
  localparam int DEF_REPEAT_DELAY      = 100;
  localparam int DEF_REPEAT_PERIOD     = 25;
  localparam logic [BTN_N-1:0] DEF_REPEAT_MASK = 6'b001111;

  // Channel FSM states
  // state         | meaning
  // ST_ARM        | after reset; waiting for a clean release before arming
  // ST_IDLE       | button accepted as released
  // ST_PRESS_WAIT | candidate press, counting stable pressed samples
  // ST_PRESSED    | press accepted; level high, auto-repeat timing runs
  // ST_REL_WAIT   | candidate release, counting stable released samples
  localparam logic [2:0] ST_ARM        = 3'd0;
  localparam logic [2:0] ST_IDLE       = 3'd1;
  localparam logic [2:0] ST_PRESS_WAIT = 3'd2;
  localparam logic [2:0] ST_PRESSED    = 3'd3;
  localparam logic [2:0] ST_REL_WAIT   = 3'd4;

  localparam int BTN_ADD1 = 0;
  localparam int BTN_ADD2 = 1;
  localparam int BTN_ADD3 = 2;
  localparam int BTN_ADD4 = 3;
  localparam int BTN_RST1 = 4;
  localparam int BTN_RST2 = 5;

endpackage

// File: rtl/button_conditioner_channel.sv
// One pushbutton channel: 2-FF synchroniser, debounce FSM, optional
// auto-repeat and registered outputs.
// Ports:
//  clk    in  1  system clock
//  rst    in  1  asynchronous active-low reset
//  btn    in  1  raw asynchronous button, 1 = pressed
//  pulse  out 1  one-cycle press / repeat pulse
//  level  out 1  debounced level, 1 while the press is accepted
module button_conditioner_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse,
  output logic level
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCNT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

  localparam logic [CNT_W-1:0]  DEB_C   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
  localparam logic [RCNT_W-1:0] DELAY_C = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] WRAP_C  = RCNT_W'(REPEAT_DELAY + REPEAT_PERIOD);

  logic              sync_a;
  logic              s;
  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic [RCNT_W-1:0] rcnt, rcnt_nxt, rcnt_inc;
  logic              pulse_nxt, level_nxt;

  assign cnt_inc  = cnt + ONE_C;
  assign rcnt_inc = rcnt + RCNT_W'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rcnt_nxt  = rcnt;
    pulse_nxt = 1'b0;
    case (state)
      ST_ARM: begin
        // A button held through reset must be seen released before arming.
        if (s) begin
          cnt_nxt = '0;
        end else if (cnt_inc >= DEB_C) begin
          cnt_nxt   = DEB_C;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_IDLE: begin
        if (s) begin
          cnt_nxt = ONE_C;
          if (ONE_C >= DEB_C) begin
            state_nxt = ST_PRESSED;
            pulse_nxt = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            state_nxt = ST_PRESS_WAIT;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_nxt = ST_IDLE;
        end else if (cnt_inc >= DEB_C) begin
          cnt_nxt   = DEB_C;
          state_nxt = ST_PRESSED;
          pulse_nxt = 1'b1;
          rcnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          cnt_nxt   = ONE_C;
          state_nxt = (ONE_C >= DEB_C) ? ST_IDLE : ST_REL_WAIT;
        end else if (REPEAT_EN) begin
          // rcnt runs 1..DELAY for the first repeat, then cycles
          // DELAY+1..DELAY+PERIOD so each later repeat is PERIOD apart.
          if (rcnt_inc == DELAY_C) begin
            pulse_nxt = 1'b1;
            rcnt_nxt  = rcnt_inc;
          end else if (rcnt_inc == WRAP_C) begin
            pulse_nxt = 1'b1;
            rcnt_nxt  = DELAY_C;
          end else begin
            rcnt_nxt = rcnt_inc;
          end
        end
      end
      ST_REL_WAIT: begin
        // Release bounce returns to PRESSED silently; rcnt is preserved.
        if (s) begin
          state_nxt = ST_PRESSED;
        end else if (cnt_inc >= DEB_C) begin
          cnt_nxt   = DEB_C;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = ST_ARM;
        cnt_nxt   = '0;
      end
    endcase
    level_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_REL_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
      state  <= ST_ARM;
      cnt    <= '0;
      rcnt   <= '0;
      pulse  <= 1'b0;
      level  <= 1'b0;
    end else begin
      sync_a <= btn;
      s      <= sync_a;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rcnt   <= rcnt_nxt;
      pulse  <= pulse_nxt;
      level  <= level_nxt;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Input front end for parking_meter: turns the raw board pushbuttons into
// clean one-cycle pulses and debounced levels. Channels are independent;
// priority between simultaneous pulses is resolved downstream.
// Ports:
//  clk        in  1      system clock (100 Hz tick)
//  rst        in  1      asynchronous active-low reset
//  btn_in     in  N_BTN  raw buttons: [0]add1 [1]add2 [2]add3 [3]add4 [4]rst1 [5]rst2
//  pulse_out  out N_BTN  one-cycle press / repeat pulse per channel
//  level_out  out N_BTN  debounced level per channel
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN           = BTN_N,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [N_BTN-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] pulse_out,
  output logic [N_BTN-1:0] level_out
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_conditioner_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_in[i]),
      .pulse (pulse_out[i]),
      .level (level_out[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int N      = 6;
  localparam int DEB    = 4;
  localparam int DELAY  = 100;
  localparam int PERIOD = 25;
  localparam logic [N-1:0] MASK = 6'b001111;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] pulse_out;
  logic [N-1:0] level_out;

  int vectors     = 0;
  int miscompares = 0;

  button_conditioner dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .pulse_out (pulse_out),
    .level_out (level_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  // Reference model: a press is accepted once the synchronised input has
  // been 1 for DEB consecutive samples (release: 0 for DEB samples). After
  // reset a channel only arms after DEB consecutive 0 samples. Repeat time
  // counts edges where the press is accepted and the last two synced
  // samples were both 1; repeats fire at DELAY, DELAY+PERIOD, ...
  bit           m_s1 [N];
  bit           m_s2 [N];
  bit           m_last [N];
  int           m_run [N];
  bit           m_armed [N];
  bit           m_level [N];
  int           m_hold [N];
  logic [N-1:0] exp_pulse;
  logic [N-1:0] exp_level;

  always @(posedge clk or negedge rst) begin : model
    bit s;
    bit prev;
    bit p;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_last[i] = 0; m_run[i] = 0;
        m_armed[i] = 1; m_level[i] = 0; m_hold[i] = 0;
      end
      exp_pulse = '0;
      exp_level = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        s = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = btn_in[i];
        prev = m_last[i];
        if (s == m_last[i]) begin
          if (m_run[i] < DEB) m_run[i]++;
        end else begin
          m_last[i] = s;
          m_run[i] = 1;
        end
        p = 0;
        if (m_armed[i]) begin
          if (!s && m_run[i] >= DEB) m_armed[i] = 0;
        end else if (s != m_level[i] && m_run[i] >= DEB) begin
          m_level[i] = s;
          if (s) begin
            p = 1;
            m_hold[i] = 0;
          end
        end else if (m_level[i] && prev && s) begin
          m_hold[i]++;
          if (MASK[i] && m_hold[i] >= DELAY && (m_hold[i] - DELAY) % PERIOD == 0) p = 1;
        end
        exp_pulse[i] = p;
        exp_level[i] = m_level[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_in = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (pulse_out !== '0 || level_out !== '0) begin
        miscompares++;
        $display("FAIL reset_hold c=%0d pulse=%b level=%b required 0", c, pulse_out, level_out);
      end
    end
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (pulse_out !== '0 || level_out !== '0 || pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL reset_after c=%0d pulse=%b level=%b required 0", c, pulse_out, level_out);
      end
    end
  endtask

  task automatic test_held_through_reset();
    rst = 1'b0;
    btn_in = 6'b000001;
    tick(); tick(); tick();
    rst = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      vectors++;
      if (pulse_out[0] !== 1'b0 || pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL held_reset c=%0d pulse=%b exp=%b level=%b exp=%b", c, pulse_out, exp_pulse, level_out, exp_level);
      end
    end
    btn_in[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL held_release c=%0d pulse=%b exp=%b level=%b exp=%b", c, pulse_out, exp_pulse, level_out, exp_level);
      end
    end
    btn_in[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      vectors++;
      if (pulse_out[0] !== 1'(e == 6) || pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL repress e=%0d pulse=%b exp=%b level=%b exp=%b", e, pulse_out, exp_pulse, level_out, exp_level);
      end
    end
    btn_in[0] = 1'b0;
    for (int c = 0; c < 10; c++) tick();
  endtask

  task automatic test_bounce();
    logic pattern [11];
    pattern = '{1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0};
    for (int e = 0; e < 20; e++) begin
      btn_in[1] = (e < 11) ? pattern[e] : 1'b0;
      tick();
      vectors++;
      if (pulse_out[1] !== 1'b0 || level_out[1] !== 1'b0 || pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL bounce e=%0d pulse=%b exp=%b level=%b exp=%b", e, pulse_out, exp_pulse, level_out, exp_level);
      end
    end
  endtask

  task automatic test_clean_press();
    btn_in[2] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      vectors++;
      if (pulse_out[2] !== 1'(e == 6) || level_out[2] !== 1'(e >= 6 && e < 16) ||
          pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL clean_press e=%0d pulse=%b exp=%b level=%b exp=%b", e, pulse_out, exp_pulse, level_out, exp_level);
      end
      if (e == 10) btn_in[2] = 1'b0;
    end
  endtask

  task automatic test_auto_repeat(input int ch);
    logic want;
    btn_in[ch] = 1'b1;
    for (int e = 1; e <= 225; e++) begin
      tick();
      want = MASK[ch] ? 1'(e inside {6, 106, 131, 156, 181, 206}) : 1'(e == 6);
      vectors++;
      if (pulse_out[ch] !== want || pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL auto_repeat ch=%0d e=%0d pulse=%b exp=%b level=%b exp=%b", ch, e, pulse_out, exp_pulse, level_out, exp_level);
      end
      // Held long enough that the edge-206 repeat lands while still pressed.
      if (e == 205) btn_in[ch] = 1'b0;
    end
  endtask

  task automatic test_release_bounce();
    btn_in[0] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      vectors++;
      if (pulse_out[0] !== 1'(e == 6) || level_out[0] !== 1'(e >= 6 && e < 36) ||
          pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL release_bounce e=%0d pulse=%b exp=%b level=%b exp=%b", e, pulse_out, exp_pulse, level_out, exp_level);
      end
      if (e == 12) btn_in[0] = 1'b0;
      if (e == 14) btn_in[0] = 1'b1;
      if (e == 30) btn_in[0] = 1'b0;
    end
  endtask

  task automatic test_simultaneous_reset();
    btn_in = 6'b010001;
    for (int e = 1; e <= 20; e++) begin
      tick();
      vectors++;
      if (pulse_out !== ((e == 6) ? 6'b010001 : 6'b000000) || pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL simultaneous e=%0d pulse=%b exp=%b level=%b exp=%b", e, pulse_out, exp_pulse, level_out, exp_level);
      end
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (pulse_out !== '0 || level_out !== '0) begin
      miscompares++;
      $display("FAIL async_reset pulse=%b level=%b required 0", pulse_out, level_out);
    end
    tick(); tick();
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++;
      if (pulse_out !== '0 || level_out !== '0 || pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL held_after_reset c=%0d pulse=%b level=%b required 0", c, pulse_out, level_out);
      end
    end
    btn_in = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL after_reset_release c=%0d pulse=%b exp=%b level=%b exp=%b", c, pulse_out, exp_pulse, level_out, exp_level);
      end
    end
  endtask

  task automatic test_random();
    int rate;
    for (int c = 0; c < 3000; c++) begin
      rate = (c < 1500) ? 7 : 150;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, rate) == 0) btn_in[i] = ~btn_in[i];
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (pulse_out !== '0 || level_out !== '0 || exp_pulse !== '0) begin
          miscompares++;
          $display("FAIL random_reset c=%0d pulse=%b level=%b required 0", c, pulse_out, level_out);
        end
        tick();
        rst = 1'b1;
      end
      tick();
      vectors++;
      if (pulse_out !== exp_pulse || level_out !== exp_level) begin
        miscompares++;
        $display("FAIL random c=%0d btn=%b pulse=%b exp=%b level=%b exp=%b", c, btn_in, pulse_out, exp_pulse, level_out, exp_level);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    btn_in = '0;
    test_reset();
    test_held_through_reset();
    test_bounce();
    test_clean_press();
    test_auto_repeat(3);
    test_auto_repeat(5);
    test_release_bounce();
    test_simultaneous_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
